// File: rtl/banked_mt_reg_file_pkg.sv
// Shared types and helpers for the barrel-core per-thread register file.
// Holds the clear-engine state encoding and the select-width calculation.
package rv_barrel_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } clear_state_e;

    localparam int REG_ADDR_W = 5;

    // Width of a select field for n items; never below one bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/banked_mt_reg_file_clear_fsm.sv
// Sequential bank-clear engine: walks one thread's registers 1..NUM_REGS-1
// writing zero, then pulses clr_done for a single cycle.
module bank_clear_fsm
    import rv_barrel_pkg::*;
#(
    parameter  int NUM_THREADS = 8,
    parameter  int NUM_REGS    = 16,
    localparam int TW          = sel_width(NUM_THREADS),
    localparam int AW          = sel_width(NUM_REGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_req,
    input  logic [TW-1:0] clr_tid,
    output logic          clear_we,
    output logic [TW-1:0] clear_tid,
    output logic [AW-1:0] clear_idx,
    output logic          clr_busy,
    output logic          clr_done
);

    localparam logic [AW-1:0] LAST_IDX  = AW'(NUM_REGS - 1);
    localparam logic [AW-1:0] FIRST_IDX = AW'(1);

    clear_state_e  state_reg, state_next;
    logic [TW-1:0] ctid_reg, ctid_next;
    logic [AW-1:0] idx_reg, idx_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            ctid_reg  <= '0;
            idx_reg   <= FIRST_IDX;
        end else begin
            state_reg <= state_next;
            ctid_reg  <= ctid_next;
            idx_reg   <= idx_next;
        end
    end

    // Requests outside IDLE are dropped rather than queued.
    always_comb begin
        state_next = state_reg;
        ctid_next  = ctid_reg;
        idx_next   = idx_reg;
        case (state_reg)
            IDLE: begin
                if (clr_req) begin
                    state_next = CLEAR;
                    ctid_next  = clr_tid;
                    idx_next   = FIRST_IDX;
                end
            end
            CLEAR: begin
                if (idx_reg == LAST_IDX) begin
                    state_next = DONE;
                    idx_next   = FIRST_IDX;
                end else begin
                    idx_next = idx_reg + AW'(1);
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        clear_we = 1'b0;
        clr_busy = 1'b0;
        clr_done = 1'b0;
        case (state_reg)
            CLEAR: begin
                clear_we = 1'b1;
                clr_busy = 1'b1;
            end
            DONE:    clr_done = 1'b1;
            default: ;
        endcase
    end

    assign clear_tid = ctid_reg;
    assign clear_idx = idx_reg;

endmodule

// File: rtl/banked_mt_reg_file.sv
// Per-hart register file: NUM_THREADS banks, two async read ports with
// optional write bypass, one write port, and a per-bank clear engine.
module banked_mt_reg_file
    import rv_barrel_pkg::*;
#(
    parameter  int NUM_THREADS = 8,
    parameter  int DATA_WIDTH  = 32,
    parameter  int NUM_REGS    = 16,
    parameter  int BYPASS      = 1,
    localparam int TW          = sel_width(NUM_THREADS),
    localparam int AW          = sel_width(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [TW-1:0]         tid_read,
    input  logic [REG_ADDR_W-1:0] a1,
    input  logic [REG_ADDR_W-1:0] a2,
    output logic [DATA_WIDTH-1:0] rd1,
    output logic [DATA_WIDTH-1:0] rd2,
    input  logic                  write_enable,
    input  logic [TW-1:0]         tid_write,
    input  logic [REG_ADDR_W-1:0] a3,
    input  logic [DATA_WIDTH-1:0] wd3,
    input  logic                  clr_req,
    input  logic [TW-1:0]         clr_tid,
    output logic                  clr_busy,
    output logic                  clr_done,
    output logic                  wr_drop
);

    logic                  clear_we;
    logic [TW-1:0]         clear_tid;
    logic [AW-1:0]         clear_idx;
    logic [AW-1:0]         a3_idx;
    logic                  usr_drop;
    logic                  usr_we;
    logic                  wr_drop_reg;
    logic [DATA_WIDTH-1:0] bank_reg [NUM_THREADS][NUM_REGS];
    logic [AW-1:0]         ra_idx   [2];
    logic [DATA_WIDTH-1:0] rd_data  [2];

    bank_clear_fsm #(
        .NUM_THREADS(NUM_THREADS),
        .NUM_REGS   (NUM_REGS)
    ) u_clear (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_req  (clr_req),
        .clr_tid  (clr_tid),
        .clear_we (clear_we),
        .clear_tid(clear_tid),
        .clear_idx(clear_idx),
        .clr_busy (clr_busy),
        .clr_done (clr_done)
    );

    generate
        if (AW < REG_ADDR_W) begin : g_addr_trim
            logic addr_unused;
            assign addr_unused = ^{a1[REG_ADDR_W-1:AW], a2[REG_ADDR_W-1:AW], a3[REG_ADDR_W-1:AW]};
        end
    endgenerate

    assign a3_idx    = a3[AW-1:0];
    assign ra_idx[0] = a1[AW-1:0];
    assign ra_idx[1] = a2[AW-1:0];

    // The whole bank being wiped is locked against user writes, any index.
    assign usr_drop = write_enable && clear_we && (tid_write == clear_tid);
    assign usr_we   = write_enable && !usr_drop && (a3_idx != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                for (int r = 0; r < NUM_REGS; r++) begin
                    bank_reg[t][r] <= '0;
                end
            end
        end else begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                for (int r = 0; r < NUM_REGS; r++) begin
                    if (clear_we && (TW'(t) == clear_tid) && (AW'(r) == clear_idx)) begin
                        bank_reg[t][r] <= '0;
                    end else if (usr_we && (TW'(t) == tid_write) && (AW'(r) == a3_idx)) begin
                        bank_reg[t][r] <= wd3;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_drop_reg <= 1'b0;
        end else begin
            wr_drop_reg <= usr_drop;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic byp_hit;
            assign byp_hit = (BYPASS != 0) && usr_we && (tid_write == tid_read)
                             && (a3_idx == ra_idx[gi]);
            assign rd_data[gi] = (ra_idx[gi] == '0) ? '0 :
                                 byp_hit            ? wd3 :
                                                      bank_reg[tid_read][ra_idx[gi]];
        end
    endgenerate

    assign rd1     = rd_data[0];
    assign rd2     = rd_data[1];
    assign wr_drop = wr_drop_reg;

endmodule

// File: tb/tb_banked_mt_reg_file.sv
// Randomised and directed bench for banked_mt_reg_file against a behavioural
// model; a bypass and a non-bypass instance share the same stimulus.
module tb_banked_mt_reg_file;

    localparam int NT = 8;
    localparam int DW = 32;
    localparam int NR = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [2:0]    tid_read, tid_write, clr_tid;
    logic [4:0]    a1, a2, a3;
    logic [DW-1:0] wd3;
    logic          write_enable, clr_req;
    logic [DW-1:0] rd1_b, rd2_b, rd1_n, rd2_n;
    logic          busy_b, done_b, drop_b, busy_n, done_n, drop_n;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] m_mem [NT][NR];
    int            m_pos;
    logic [2:0]    m_ctid;
    bit            m_done;
    bit            m_drop_q;

    always #5 clk = ~clk;

    banked_mt_reg_file #(.NUM_THREADS(NT), .DATA_WIDTH(DW), .NUM_REGS(NR), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .tid_read(tid_read), .a1(a1), .a2(a2), .rd1(rd1_b), .rd2(rd2_b),
        .write_enable(write_enable), .tid_write(tid_write), .a3(a3), .wd3(wd3),
        .clr_req(clr_req), .clr_tid(clr_tid), .clr_busy(busy_b), .clr_done(done_b), .wr_drop(drop_b)
    );

    banked_mt_reg_file #(.NUM_THREADS(NT), .DATA_WIDTH(DW), .NUM_REGS(NR), .BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .tid_read(tid_read), .a1(a1), .a2(a2), .rd1(rd1_n), .rd2(rd2_n),
        .write_enable(write_enable), .tid_write(tid_write), .a3(a3), .wd3(wd3),
        .clr_req(clr_req), .clr_tid(clr_tid), .clr_busy(busy_n), .clr_done(done_n), .wr_drop(drop_n)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int t = 0; t < NT; t++)
            for (int r = 0; r < NR; r++)
                m_mem[t][r] = '0;
        m_pos    = 0;
        m_ctid   = '0;
        m_done   = 1'b0;
        m_drop_q = 1'b0;
    endtask

    function automatic bit model_drop();
        return write_enable && (m_pos != 0) && (tid_write == m_ctid);
    endfunction

    function automatic logic [DW-1:0] exp_rd(input logic [4:0] a, input bit byp);
        int i = int'(a[3:0]);
        if (i == 0) return '0;
        if (byp && write_enable && !model_drop() && tid_write == tid_read && int'(a3[3:0]) == i)
            return wd3;
        return m_mem[tid_read][i];
    endfunction

    task automatic check_cycle();
        chk("rd1", rd1_b, exp_rd(a1, 1'b1));
        chk("rd2", rd2_b, exp_rd(a2, 1'b1));
        chk("rd1_nb", rd1_n, exp_rd(a1, 1'b0));
        chk("rd2_nb", rd2_n, exp_rd(a2, 1'b0));
        chk("clr_busy", 32'(busy_b), 32'(m_pos != 0));
        chk("clr_done", 32'(done_b), 32'(m_done));
        chk("wr_drop", 32'(drop_b), 32'(m_drop_q));
        chk("clr_busy_nb", 32'(busy_n), 32'(m_pos != 0));
        chk("wr_drop_nb", 32'(drop_n), 32'(m_drop_q));
    endtask

    // One clock edge of the reference behaviour, using the inputs now applied.
    task automatic model_edge();
        bit drop = model_drop();
        if (write_enable && !drop && a3[3:0] != 4'd0)
            m_mem[tid_write][a3[3:0]] = wd3;
        if (m_pos != 0) begin
            m_mem[m_ctid][m_pos] = '0;
            if (m_pos == NR - 1) begin
                m_pos  = 0;
                m_done = 1'b1;
            end else begin
                m_pos++;
            end
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (clr_req) begin
            m_ctid = clr_tid;
            m_pos  = 1;
        end
        m_drop_q = drop;
    endtask

    task automatic step();
        @(negedge clk);
        check_cycle();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        write_enable = 1'b0;
        clr_req      = 1'b0;
        a1 = '0; a2 = '0; a3 = '0;
        wd3 = '0;
    endtask

    task automatic do_write(input logic [2:0] t, input logic [4:0] a, input logic [DW-1:0] d);
        write_enable = 1'b1;
        tid_write    = t;
        a3           = a;
        wd3          = d;
        step();
        write_enable = 1'b0;
    endtask

    initial begin
        int busy_cnt;
        int done_at;

        rst_n = 1'b0;
        tid_read = '0; tid_write = '0; clr_tid = '0;
        idle_in();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy_b), 32'd0);
        chk("rst_done", 32'(done_b), 32'd0);
        chk("rst_drop", 32'(drop_b), 32'd0);
        a1 = 5'd5; tid_read = 3'd3;
        #1;
        chk("rst_rd", rd1_b, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic write / read isolation between threads
        do_write(3'd3, 5'd5, 32'hDEADBEEF);
        tid_read = 3'd3; a1 = 5'd5; a2 = 5'd0;
        #1;
        chk("t3_x5", rd1_b, 32'hDEADBEEF);
        chk("x0_zero", rd2_b, 32'd0);
        step();
        tid_read = 3'd2;
        #1;
        chk("t2_x5", rd1_b, 32'd0);
        step();

        // Same-cycle bypass versus stored value
        write_enable = 1'b1; tid_write = 3'd1; a3 = 5'd7; wd3 = 32'h1234;
        tid_read = 3'd1; a1 = 5'd7;
        #1;
        chk("bypass", rd1_b, 32'h1234);
        chk("nobypass_old", rd1_n, 32'd0);
        step();
        idle_in();
        tid_read = 3'd1; a1 = 5'd7;
        #1;
        chk("nobypass_new", rd1_n, 32'h1234);
        step();

        // Upper address bits ignored
        do_write(3'd0, 5'd20, 32'hAA);
        idle_in();
        tid_read = 3'd0; a1 = 5'd4; a2 = 5'd20;
        #1;
        chk("alias_rd4", rd1_b, 32'hAA);
        chk("alias_rd20", rd2_b, 32'hAA);
        step();

        // Full bank clear of T4, T5 untouched
        for (int i = 1; i < NR; i++) begin
            do_write(3'd4, 5'(i), 32'h100 + 32'(i));
            do_write(3'd5, 5'(i), 32'h200 + 32'(i));
        end
        idle_in();
        clr_req = 1'b1; clr_tid = 3'd4;
        step();
        clr_req = 1'b0;
        busy_cnt = 0;
        done_at  = 0;
        for (int c = 1; c <= 40 && done_at == 0; c++) begin
            if (busy_b) busy_cnt++;
            if (done_b) done_at = c;
            step();
        end
        chk("busy_len", 32'(busy_cnt), 32'd15);
        chk("done_at", 32'(done_at), 32'd16);
        for (int i = 0; i < NR; i++) begin
            tid_read = 3'd4; a1 = 5'(i);
            #1;
            chk("t4_cleared", rd1_b, 32'd0);
            step();
            tid_read = 3'd5;
            #1;
            chk("t5_kept", rd1_b, (i == 0) ? 32'd0 : 32'h200 + 32'(i));
            step();
        end

        // Write conflicts during a T2 clear, second request ignored
        do_write(3'd2, 5'd3, 32'h11);
        clr_req = 1'b1; clr_tid = 3'd2;
        step();
        clr_req = 1'b0;
        step();
        write_enable = 1'b1; tid_write = 3'd2; a3 = 5'd3; wd3 = 32'h55;
        tid_read = 3'd2; a1 = 5'd3;
        #1;
        chk("drop_no_bypass", rd1_b, 32'h11);
        step();
        tid_write = 3'd6; wd3 = 32'h66;
        clr_req = 1'b1; clr_tid = 3'd6;
        #1;
        chk("drop_pulse", 32'(drop_b), 32'd1);
        step();
        idle_in();
        tid_read = 3'd6; a1 = 5'd3;
        #1;
        chk("drop_clear", 32'(drop_b), 32'd0);
        chk("t6_written", rd1_b, 32'h66);
        repeat (25) step();
        chk("t6_not_cleared", rd1_b, 32'h66);
        tid_read = 3'd2;
        #1;
        chk("t2_dropped", rd1_b, 32'd0);
        step();

        // Reset in the middle of a clear
        do_write(3'd7, 5'd9, 32'h77);
        clr_req = 1'b1; clr_tid = 3'd7;
        step();
        clr_req = 1'b0;
        repeat (4) step();
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy_b), 32'd0);
        chk("abort_done", 32'(done_b), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int t = 0; t < NT; t++) begin
            for (int i = 0; i < NR; i++) begin
                tid_read = 3'(t); a1 = 5'(i); a2 = 5'(i + 16);
                #1;
                chk("post_rst", rd1_b, 32'd0);
                step();
            end
        end

        // Randomised traffic, clears included
        for (int n = 0; n < 3000; n++) begin
            write_enable = 1'($urandom_range(0, 1));
            tid_write    = 3'($urandom_range(0, NT - 1));
            a3           = 5'($urandom_range(0, 31));
            wd3          = $urandom;
            tid_read     = 3'($urandom_range(0, NT - 1));
            a1           = 5'($urandom_range(0, 31));
            a2           = 5'($urandom_range(0, 31));
            clr_req      = ($urandom_range(0, 15) == 0);
            clr_tid      = 3'($urandom_range(0, NT - 1));
            step();
        end
        idle_in();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
